// File: rtl/butterfly_writeback_packer_pkg.sv
// Shared memory-word layout, write masks, write FSM encodings and the field packer
// used on the butterfly write-back path into the 24-bit data memory.
package butterfly_writeback_packer_pkg;

  localparam int MEM_W   = 24;
  localparam int FP8_MSB = 23;
  localparam int FP8_LSB = 8;
  localparam int FP4_MSB = 7;
  localparam int FP4_LSB = 0;

  localparam logic [1:0] MASK_FP8 = 2'b10;
  localparam logic [1:0] MASK_FP4 = 2'b01;
  localparam logic [1:0] MASK_ALL = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WR_X = 2'd1;
  localparam logic [1:0] ST_WR_Y = 2'd2;

  typedef struct packed {
    logic [MEM_W-1:0] wdata;
    logic [1:0]       wmask;
  } mem_word_t;

  // With clear_other the idle field is written as zero instead of being masked off.
  function automatic mem_word_t pack_word(input logic [15:0] v, input logic is_fp8,
                                          input logic clear_other);
    mem_word_t w;
    w.wdata = '0;
    if (is_fp8) begin
      w.wdata[FP8_MSB:FP8_LSB] = v;
      w.wmask = clear_other ? MASK_ALL : MASK_FP8;
    end else begin
      w.wdata[FP4_MSB:FP4_LSB] = v[7:0];
      w.wmask = clear_other ? MASK_ALL : MASK_FP4;
    end
    return w;
  endfunction

endpackage

// File: rtl/butterfly_writeback_packer_if.sv
// Result-pair input handshake plus single-port memory write bus; master = producer/memory
// side, slave = the packer.
interface butterfly_writeback_packer_if #(parameter int ADDR_W = 4);
  import butterfly_writeback_packer_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_x;
  logic [15:0]       in_y;
  logic              in_is_fp8;
  logic [ADDR_W-1:0] in_addr_x;
  logic [ADDR_W-1:0] in_addr_y;

  logic              mem_we;
  logic              mem_gnt;
  logic [ADDR_W-1:0] mem_addr;
  logic [MEM_W-1:0]  mem_wdata;
  logic [1:0]        mem_wmask;

  modport master (
    output in_valid, in_x, in_y, in_is_fp8, in_addr_x, in_addr_y, mem_gnt,
    input  in_ready, mem_we, mem_addr, mem_wdata, mem_wmask
  );

  modport slave (
    input  in_valid, in_x, in_y, in_is_fp8, in_addr_x, in_addr_y, mem_gnt,
    output in_ready, mem_we, mem_addr, mem_wdata, mem_wmask
  );

endinterface

// File: rtl/butterfly_writeback_packer_fifo.sv
// Synchronous pair FIFO, zero-latency head (dout = oldest entry); push ignored when full,
// pop ignored when empty, simultaneous push+pop allowed when not full.
module butterfly_writeback_packer_fifo #(
  parameter int WIDTH = 41,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0] PTR_ONE  = (PW+1)'(1);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = store[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/butterfly_writeback_packer.sv
// Buffers butterfly result pairs and writes X then Y into the 24-bit memory; first write one
// cycle after an accept into an empty FIFO; in_ready drops while the FIFO is full.
module butterfly_writeback_packer
  import butterfly_writeback_packer_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int FIFO_DEPTH  = 2,
  parameter int CLEAR_OTHER = 0,
  parameter int CNT_W       = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  butterfly_writeback_packer_if.slave  bus,
  input  logic                         stat_clr,
  output logic                         busy,
  output logic [CNT_W-1:0]             pairs_written,
  output logic                         fmt_err
);

  localparam logic CLR_OTHER = (CLEAR_OTHER != 0);
  localparam int   CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef struct packed {
    logic [15:0]       x;
    logic [15:0]       y;
    logic              is_fp8;
    logic [ADDR_W-1:0] addr_x;
    logic [ADDR_W-1:0] addr_y;
  } entry_t;

  entry_t        in_entry;
  entry_t        head;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          has_next;
  logic [1:0]    state;
  logic [1:0]    state_nxt;
  mem_word_t     word;

  assign in_entry     = '{x: bus.in_x, y: bus.in_y, is_fp8: bus.in_is_fp8,
                          addr_x: bus.in_addr_x, addr_y: bus.in_addr_y};
  assign bus.in_ready = !full;
  assign push         = bus.in_valid && !full;
  assign pop          = (state == ST_WR_Y) && bus.mem_gnt;
  // The head is the entry being popped, so another pair remains if a second one is queued or arriving now.
  assign has_next     = (count != CNT_ONE) || push;
  assign busy         = !empty || (state != ST_IDLE);

  butterfly_writeback_packer_fifo #(
    .WIDTH (33 + 2*ADDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (in_entry),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (!empty)      state_nxt = ST_WR_X;
      ST_WR_X: if (bus.mem_gnt) state_nxt = ST_WR_Y;
      ST_WR_Y: if (bus.mem_gnt) state_nxt = has_next ? ST_WR_X : ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Write bus is purely state + FIFO head, so it holds steady while the grant is withheld.
  always_comb begin
    word          = '0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    case (state)
      ST_WR_X: begin
        bus.mem_we   = 1'b1;
        bus.mem_addr = head.addr_x;
        word         = pack_word(head.x, head.is_fp8, CLR_OTHER);
      end
      ST_WR_Y: begin
        bus.mem_we   = 1'b1;
        bus.mem_addr = head.addr_y;
        word         = pack_word(head.y, head.is_fp8, CLR_OTHER);
      end
      default: ;
    endcase
    bus.mem_wdata = word.wdata;
    bus.mem_wmask = word.wmask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pairs_written <= '0;
      fmt_err       <= 1'b0;
    end else if (stat_clr) begin
      pairs_written <= '0;
      fmt_err       <= 1'b0;
    end else begin
      if (pop) pairs_written <= pairs_written + CNT_W'(1);
      if (push && !bus.in_is_fp8 && ((bus.in_x[15:8] | bus.in_y[15:8]) != 8'h00))
        fmt_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_butterfly_writeback_packer.sv
// Drives two packers (masked and clear-other) with identical pairs and checks writes,
// counters and flags against a queue-based model of expected memory writes.
module tb_butterfly_writeback_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_x;
  logic [15:0] in_y;
  logic        in_is_fp8;
  logic [3:0]  in_addr_x;
  logic [3:0]  in_addr_y;
  logic        mem_gnt;
  logic        stat_clr;
  logic        busy_a, busy_b, fmt_a, fmt_b;
  logic [7:0]  pairs_a, pairs_b;

  int checks   = 0;
  int failures = 0;

  // Write record: {addr[3:0], wdata[23:0], wmask[1:0]}
  logic [29:0] exp_a[$];
  logic [29:0] exp_b[$];
  logic [29:0] obs_a[$];
  logic [29:0] obs_b[$];

  butterfly_writeback_packer_if #(.ADDR_W(4)) a_if();
  butterfly_writeback_packer_if #(.ADDR_W(4)) b_if();

  assign a_if.in_valid  = in_valid;   assign b_if.in_valid  = in_valid;
  assign a_if.in_x      = in_x;       assign b_if.in_x      = in_x;
  assign a_if.in_y      = in_y;       assign b_if.in_y      = in_y;
  assign a_if.in_is_fp8 = in_is_fp8;  assign b_if.in_is_fp8 = in_is_fp8;
  assign a_if.in_addr_x = in_addr_x;  assign b_if.in_addr_x = in_addr_x;
  assign a_if.in_addr_y = in_addr_y;  assign b_if.in_addr_y = in_addr_y;
  assign a_if.mem_gnt   = mem_gnt;    assign b_if.mem_gnt   = mem_gnt;

  butterfly_writeback_packer #(.ADDR_W(4), .FIFO_DEPTH(2), .CLEAR_OTHER(0), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if.slave), .stat_clr(stat_clr),
    .busy(busy_a), .pairs_written(pairs_a), .fmt_err(fmt_a));

  butterfly_writeback_packer #(.ADDR_W(4), .FIFO_DEPTH(2), .CLEAR_OTHER(1), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if.slave), .stat_clr(stat_clr),
    .busy(busy_b), .pairs_written(pairs_b), .fmt_err(fmt_b));

  // FP8 occupies the upper 16 bits, FP4 only the low byte.
  function automatic logic [29:0] model_wr(input logic [3:0] addr, input logic [15:0] v,
                                           input logic fp8, input bit clr);
    logic [23:0] d;
    logic [1:0]  m;
    d = fp8 ? 24'(v) * 24'd256 : 24'(v % 16'd256);
    m = clr ? 2'd3 : (fp8 ? 2'd2 : 2'd1);
    return {addr, d, m};
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (a_if.mem_we && mem_gnt) obs_a.push_back({a_if.mem_addr, a_if.mem_wdata, a_if.mem_wmask});
      if (b_if.mem_we && mem_gnt) obs_b.push_back({b_if.mem_addr, b_if.mem_wdata, b_if.mem_wmask});
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_queues();
    exp_a.delete(); exp_b.delete(); obs_a.delete(); obs_b.delete();
  endtask

  task automatic send_pair(input logic [15:0] x, input logic [15:0] y, input logic fp8,
                           input logic [3:0] ax, input logic [3:0] ay);
    bit ok = 0;
    in_x = x; in_y = y; in_is_fp8 = fp8; in_addr_x = ax; in_addr_y = ay; in_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk); ok = a_if.in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL send_accept: in_ready stayed 0 for 100 cycles, required 1");
    end else begin
      exp_a.push_back(model_wr(ax, x, fp8, 0)); exp_a.push_back(model_wr(ay, y, fp8, 0));
      exp_b.push_back(model_wr(ax, x, fp8, 1)); exp_b.push_back(model_wr(ay, y, fp8, 1));
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((busy_a || busy_b) && n < 500) begin tick(); n++; end
    checks++;
    if (busy_a || busy_b) begin
      failures++;
      $display("FAIL drain_timeout: busy=%b/%b after 500 cycles, required 0/0", busy_a, busy_b);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_is_fp8 = 1'b0;
    in_addr_x = '0; in_addr_y = '0; mem_gnt = 1'b0; stat_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    checks++; if (a_if.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b required 1", a_if.in_ready); end
    checks++; if (a_if.mem_we !== 1'b0 || b_if.mem_we !== 1'b0) begin failures++; $display("FAIL reset_we: got %b/%b required 0/0", a_if.mem_we, b_if.mem_we); end
    checks++; if (a_if.mem_addr !== 4'h0) begin failures++; $display("FAIL reset_addr: got %h required 0", a_if.mem_addr); end
    checks++; if (a_if.mem_wdata !== 24'h0 || a_if.mem_wmask !== 2'b00) begin failures++; $display("FAIL reset_wdata: got %h/%b required 0/00", a_if.mem_wdata, a_if.mem_wmask); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy_a); end
    checks++; if (pairs_a !== 8'd0 || fmt_a !== 1'b0) begin failures++; $display("FAIL reset_stats: got %0d/%b required 0/0", pairs_a, fmt_a); end
  endtask

  task automatic test_fp8_pair();
    clear_queues();
    mem_gnt = 1'b1;
    send_pair(16'h3C80, 16'hBC00, 1'b1, 4'd3, 4'd11);
    checks++; if (a_if.mem_we !== 1'b0 || busy_a !== 1'b1) begin failures++; $display("FAIL fp8_accept_edge: we/busy %b/%b required 0/1", a_if.mem_we, busy_a); end
    tick();
    checks++; if ({a_if.mem_we, a_if.mem_addr, a_if.mem_wdata, a_if.mem_wmask} !== {1'b1, 4'd3, 24'h3C8000, 2'b10}) begin failures++; $display("FAIL fp8_x_write: got we=%b a=%h d=%h m=%b required 1 3 3c8000 10", a_if.mem_we, a_if.mem_addr, a_if.mem_wdata, a_if.mem_wmask); end
    checks++; if (b_if.mem_wmask !== 2'b11) begin failures++; $display("FAIL fp8_x_mask_clr: got %b required 11", b_if.mem_wmask); end
    tick();
    checks++; if ({a_if.mem_we, a_if.mem_addr, a_if.mem_wdata, a_if.mem_wmask} !== {1'b1, 4'd11, 24'hBC0000, 2'b10}) begin failures++; $display("FAIL fp8_y_write: got we=%b a=%h d=%h m=%b required 1 b bc0000 10", a_if.mem_we, a_if.mem_addr, a_if.mem_wdata, a_if.mem_wmask); end
    tick();
    checks++; if (a_if.mem_we !== 1'b0 || pairs_a !== 8'd1 || pairs_b !== 8'd1) begin failures++; $display("FAIL fp8_done: we=%b pairs=%0d/%0d required 0 1/1", a_if.mem_we, pairs_a, pairs_b); end
  endtask

  task automatic test_fp4_clear();
    logic [3:0] ax, ay;
    clear_queues();
    mem_gnt = 1'b1;
    ax = 4'($urandom); ay = 4'($urandom);
    send_pair(16'h0035, 16'h00A2, 1'b0, ax, ay);
    drain();
    checks++; if (obs_a.size() != 2 || obs_b.size() != 2) begin failures++; $display("FAIL fp4_count: got %0d/%0d writes required 2/2", obs_a.size(), obs_b.size()); end
    for (int i = 0; i < 2 && i < obs_a.size() && i < obs_b.size(); i++) begin
      checks++;
      if (obs_a[i] !== exp_a[i] || obs_b[i] !== exp_b[i]) begin failures++; $display("FAIL fp4_write%0d: got %h/%h required %h/%h", i, obs_a[i], obs_b[i], exp_a[i], exp_b[i]); end
    end
    checks++; if (fmt_a !== 1'b0 || fmt_b !== 1'b0) begin failures++; $display("FAIL fp4_fmt_err: got %b/%b required 0/0", fmt_a, fmt_b); end
  endtask

  task automatic test_gnt_stall();
    logic [29:0] x1;
    clear_queues();
    mem_gnt = 1'b0;
    send_pair(16'($urandom), 16'($urandom), 1'b1, 4'($urandom), 4'($urandom));
    x1 = exp_a[0];
    tick();
    checks++; if ({a_if.mem_we, a_if.mem_addr, a_if.mem_wdata, a_if.mem_wmask} !== {1'b1, x1}) begin failures++; $display("FAIL stall_hold0: got %b %h required 1 %h", a_if.mem_we, {a_if.mem_addr, a_if.mem_wdata, a_if.mem_wmask}, x1); end
    send_pair({8'h00, 8'($urandom)}, {8'h00, 8'($urandom)}, 1'b0, 4'($urandom), 4'($urandom));
    checks++; if (a_if.in_ready !== 1'b0) begin failures++; $display("FAIL stall_full_ready: got %b required 0", a_if.in_ready); end
    for (int i = 1; i < 5; i++) begin
      checks++;
      if ({a_if.mem_we, a_if.mem_addr, a_if.mem_wdata, a_if.mem_wmask} !== {1'b1, x1}) begin failures++; $display("FAIL stall_hold%0d: got %b %h required 1 %h", i, a_if.mem_we, {a_if.mem_addr, a_if.mem_wdata, a_if.mem_wmask}, x1); end
      tick();
    end
    fork
      send_pair(16'($urandom), 16'($urandom), 1'b1, 4'($urandom), 4'($urandom));
      begin tick(); tick(); mem_gnt = 1'b1; end
    join
    drain();
    checks++; if (obs_a.size() != 6 || obs_b.size() != 6) begin failures++; $display("FAIL stall_count: got %0d/%0d writes required 6/6", obs_a.size(), obs_b.size()); end
    for (int i = 0; i < 6 && i < obs_a.size() && i < obs_b.size() && i < exp_a.size(); i++) begin
      checks++;
      if (obs_a[i] !== exp_a[i] || obs_b[i] !== exp_b[i]) begin failures++; $display("FAIL stall_write%0d: got %h/%h required %h/%h", i, obs_a[i], obs_b[i], exp_a[i], exp_b[i]); end
    end
  endtask

  task automatic test_fmt_err();
    clear_queues();
    mem_gnt = 1'b1;
    stat_clr = 1'b1; tick(); stat_clr = 1'b0;
    send_pair(16'h0135, 16'h0012, 1'b0, 4'd5, 4'd6);
    drain();
    checks++; if (fmt_a !== 1'b1 || fmt_b !== 1'b1) begin failures++; $display("FAIL fmt_set: got %b/%b required 1/1", fmt_a, fmt_b); end
    checks++; if (obs_a.size() < 1 || obs_a[0] !== {4'd5, 24'h000035, 2'b01}) begin failures++; $display("FAIL fmt_x_data: got %h required %h", (obs_a.size() > 0) ? obs_a[0] : 30'h0, {4'd5, 24'h000035, 2'b01}); end
    send_pair(16'($urandom), 16'($urandom), 1'b1, 4'($urandom), 4'($urandom));
    drain();
    checks++; if (fmt_a !== 1'b1 || pairs_a !== 8'd2) begin failures++; $display("FAIL fmt_sticky: fmt=%b pairs=%0d required 1 2", fmt_a, pairs_a); end
    stat_clr = 1'b1; tick(); stat_clr = 1'b0;
    checks++; if (fmt_a !== 1'b0 || pairs_a !== 8'd0) begin failures++; $display("FAIL stat_clr: fmt=%b pairs=%0d required 0 0", fmt_a, pairs_a); end
    stat_clr = 1'b1;
    send_pair(16'hFF01, 16'h0002, 1'b0, 4'($urandom), 4'($urandom));
    drain();
    stat_clr = 1'b0;
    checks++; if (fmt_a !== 1'b0 || pairs_a !== 8'd0) begin failures++; $display("FAIL clr_wins: fmt=%b pairs=%0d required 0 0", fmt_a, pairs_a); end
    checks++; if (obs_a.size() != 6) begin failures++; $display("FAIL fmt_count: got %0d writes required 6", obs_a.size()); end
    for (int i = 0; i < 6 && i < obs_a.size() && i < obs_b.size(); i++) begin
      checks++;
      if (obs_a[i] !== exp_a[i] || obs_b[i] !== exp_b[i]) begin failures++; $display("FAIL fmt_write%0d: got %h/%h required %h/%h", i, obs_a[i], obs_b[i], exp_a[i], exp_b[i]); end
    end
  endtask

  task automatic test_reset_midway();
    logic [3:0] ay1;
    clear_queues();
    mem_gnt = 1'b1;
    send_pair(16'h1234, 16'h5678, 1'b1, 4'd1, 4'd2);
    drain();
    mem_gnt = 1'b0;
    ay1 = 4'($urandom);
    send_pair(16'($urandom), 16'($urandom), 1'b1, 4'd7, ay1);
    tick();
    send_pair(16'($urandom), 16'($urandom), 1'b1, 4'd8, 4'd9);
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    checks++; if (a_if.mem_we !== 1'b1 || a_if.mem_addr !== ay1) begin failures++; $display("FAIL midrst_in_wr_y: we=%b addr=%h required 1 %h", a_if.mem_we, a_if.mem_addr, ay1); end
    obs_a.delete(); obs_b.delete();
    rst_n = 1'b0;
    #1;
    checks++; if (a_if.mem_we !== 1'b0 || b_if.mem_we !== 1'b0) begin failures++; $display("FAIL midrst_we: got %b/%b required 0/0", a_if.mem_we, b_if.mem_we); end
    checks++; if (busy_a !== 1'b0 || pairs_a !== 8'd0) begin failures++; $display("FAIL midrst_state: busy=%b pairs=%0d required 0 0", busy_a, pairs_a); end
    tick(); tick();
    rst_n = 1'b1;
    mem_gnt = 1'b1;
    repeat (10) tick();
    checks++; if (obs_a.size() != 0 || obs_b.size() != 0) begin failures++; $display("FAIL midrst_no_writes: got %0d/%0d writes required 0/0", obs_a.size(), obs_b.size()); end
    checks++; if (busy_a !== 1'b0 || a_if.in_ready !== 1'b1) begin failures++; $display("FAIL midrst_idle: busy=%b ready=%b required 0 1", busy_a, a_if.in_ready); end
  endtask

  task automatic test_back_to_back();
    int n = 0, cyc = 0, we_cnt = 0, first = -1, last = -1;
    bit acc;
    clear_queues();
    mem_gnt = 1'b1;
    stat_clr = 1'b1; tick(); stat_clr = 1'b0;
    in_x = 16'($urandom); in_y = 16'($urandom); in_is_fp8 = 1'($urandom_range(0, 1));
    in_addr_x = 4'($urandom); in_addr_y = 4'($urandom); in_valid = 1'b1;
    while ((n < 257 || busy_a || busy_b) && cyc < 3000) begin
      @(negedge clk);
      acc = in_valid && a_if.in_ready;
      if (a_if.mem_we) begin we_cnt++; if (first < 0) first = cyc; last = cyc; end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        exp_a.push_back(model_wr(in_addr_x, in_x, in_is_fp8, 0)); exp_a.push_back(model_wr(in_addr_y, in_y, in_is_fp8, 0));
        exp_b.push_back(model_wr(in_addr_x, in_x, in_is_fp8, 1)); exp_b.push_back(model_wr(in_addr_y, in_y, in_is_fp8, 1));
        n++;
        if (n < 257) begin
          in_x = 16'($urandom); in_y = 16'($urandom); in_is_fp8 = 1'($urandom_range(0, 1));
          in_addr_x = 4'($urandom); in_addr_y = 4'($urandom);
        end else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    checks++; if (n != 257 || busy_a) begin failures++; $display("FAIL b2b_complete: accepted %0d busy=%b required 257 0", n, busy_a); end
    checks++; if (we_cnt != 514 || (last - first + 1) != 514) begin failures++; $display("FAIL b2b_rate: writes=%0d span=%0d required 514 514", we_cnt, last - first + 1); end
    checks++; if (pairs_a !== 8'd1 || pairs_b !== 8'd1) begin failures++; $display("FAIL b2b_wrap: got %0d/%0d required 1/1", pairs_a, pairs_b); end
    checks++; if (obs_a.size() != exp_a.size() || obs_b.size() != exp_b.size()) begin failures++; $display("FAIL b2b_count: got %0d/%0d required %0d/%0d", obs_a.size(), obs_b.size(), exp_a.size(), exp_b.size()); end
    for (int i = 0; i < exp_a.size() && i < obs_a.size() && i < obs_b.size(); i++) begin
      checks++;
      if (obs_a[i] !== exp_a[i] || obs_b[i] !== exp_b[i]) begin failures++; $display("FAIL b2b_write%0d: got %h/%h required %h/%h", i, obs_a[i], obs_b[i], exp_a[i], exp_b[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_fp8_pair();
    test_fp4_clear();
    test_gnt_stall();
    test_fmt_err();
    test_reset_midway();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
